// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register-file write port between NumReq requesters.
// Define WBARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module regfile_wb_arbiter #(
  parameter int NumReq    = 4,
  parameter int DataWidth = 32,
  parameter int SelWidth  = 5
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic                          Flush,
  input  logic [NumReq-1:0]             ReqValid,
  input  logic [NumReq*SelWidth-1:0]    ReqSel,
  input  logic [NumReq*DataWidth-1:0]   ReqData,
  output logic [NumReq-1:0]             ReqReady,
  output logic                          WrEnable,
  output logic [SelWidth-1:0]           WrSel,
  output logic [DataWidth-1:0]          WrData,
  input  logic                          WrReady,
  output logic [2:0]                    LastGrant
);

  logic                 wr_en_q, wr_en_d;
  logic [SelWidth-1:0]  wr_sel_q, wr_sel_d;
  logic [DataWidth-1:0] wr_data_q, wr_data_d;
  logic [2:0]           last_grant_q, last_grant_d;

  logic                 slot_free;
  logic                 accept;
  logic                 grant_vld;
  logic [2:0]           grant_idx;
  logic [2:0]           grant_nxt;
  logic [3:0]           cand;
  logic [7:0]           req_pad;
  logic [2:0]           search_base;
  logic [NumReq-1:0]    grant_oh;
  logic [SelWidth-1:0]  grant_sel;
  logic [DataWidth-1:0] grant_data;

`ifdef WBARB_FIXED_PRIO_EN
  assign search_base = 3'd0;
`else
  logic [2:0] rr_ptr_q, rr_ptr_d;
  assign search_base = rr_ptr_q;
`endif

  // The slot can take a new write when empty or when its current write drains this cycle.
  assign slot_free = !wr_en_q || WrReady;
  assign req_pad   = 8'(ReqValid);

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 3'd0;
    cand      = 4'd0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, search_base} + 4'(k);
      if (cand >= 4'(NumReq)) cand = cand - 4'(NumReq);
      if (!grant_vld && req_pad[cand[2:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[2:0];
      end
    end
  end

  assign accept    = grant_vld && slot_free && !Flush && Reset_n;
  assign grant_nxt = (grant_idx == 3'(NumReq - 1)) ? 3'd0 : grant_idx + 3'd1;

  always_comb begin
    grant_oh   = '0;
    grant_sel  = '0;
    grant_data = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_idx == 3'(i)) begin
        grant_sel  = ReqSel[i*SelWidth +: SelWidth];
        grant_data = ReqData[i*DataWidth +: DataWidth];
        if (accept) grant_oh[i] = 1'b1;
      end
    end
  end

  assign ReqReady = grant_oh;

  always_comb begin
    wr_en_d      = wr_en_q;
    wr_sel_d     = wr_sel_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
    if (Flush) begin
      wr_en_d = 1'b0;
    end else if (slot_free) begin
      if (accept) begin
        wr_sel_d     = grant_sel;
        wr_data_d    = grant_data;
        // x0 writes are consumed but never strobed into the file.
        wr_en_d      = (grant_sel != '0);
        last_grant_d = grant_idx;
      end else begin
        wr_en_d = 1'b0;
      end
    end
  end

`ifndef WBARB_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (Flush)       rr_ptr_d = 3'd0;
    else if (accept) rr_ptr_d = grant_nxt;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) rr_ptr_q <= 3'd0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_en_q      <= 1'b0;
      wr_sel_q     <= '0;
      wr_data_q    <= '0;
      last_grant_q <= 3'd0;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_sel_q     <= wr_sel_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign WrEnable  = wr_en_q;
  assign WrSel     = wr_sel_q;
  assign WrData    = wr_data_q;
  assign LastGrant = last_grant_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Round-robin write-back arbiter for the 32-entry register file write path.
- Shares the single write port between NumReq requesters, for example ALU, load unit and CSR unit.
- Drives a registered enable, 5-bit select and 32-bit data onto the register-file write decoder, one write per cycle, with a valid/ready handshake on both sides.

Parameters:
NumReq, 4, number of requesters (2..8)
DataWidth, 32, write data width
SelWidth, 5, register index width (32 registers)

Ports:
Clock  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
Flush  input  1  synchronous flush, drops pending write and resets pointer
ReqValid  input  NumReq  per-requester write request
ReqSel  input  NumReq*SelWidth  per-requester target register index, requester i at bits [i*5+:5]
ReqData  input  NumReq*DataWidth  per-requester write data, requester i at bits [i*32+:32]
ReqReady  output  NumReq  one-hot accept; transfer happens when ReqValid[i]&ReqReady[i]
WrEnable  output  1  registered write strobe to the decoder Enable
WrSel  output  SelWidth  registered register index to the decoder Sel
WrData  output  DataWidth  registered write data
WrReady  input  1  register file accepts the write this cycle
LastGrant  output  3  index of the most recently accepted requester

Behaviour:
- Clock and reset: one clock (Clock). Reset_n is asynchronous, active-low.
- Reset values:
  - WrEnable=0, WrSel=0, WrData=0, LastGrant=0.
  - Round-robin pointer RrPtr=0.
  - ReqReady forced 0 while Reset_n=0.
- Output slot:
  - WrEnable doubles as the slot-valid bit.
  - SlotFree = !WrEnable | WrReady.
- Arbitration, combinational each cycle:
  - If Flush=1 or SlotFree=0: ReqReady=0.
  - Otherwise grant the first i with ReqValid[i]=1, searching RrPtr, RrPtr+1, ... mod NumReq.
  - ReqReady is one-hot on that i, or all-zero if there is no request.
- On an accepted transfer from requester g:
  - WrSel<=ReqSel[g], WrData<=ReqData[g].
  - WrEnable<=(ReqSel[g]!=0).
  - RrPtr<=(g+1) mod NumReq; LastGrant<=g.
- x0 writes (ReqSel=0): accepted and consumed, but WrEnable stays 0. x0 is never written.
- If the slot is free and there is no accepted transfer: WrEnable<=0. WrSel/WrData hold their values.
- If WrEnable=1 and WrReady=0: WrEnable, WrSel and WrData hold stable; no grant is issued; RrPtr is unchanged.
- Latency: accept in cycle t gives WrEnable in cycle t+1.
- Throughput: one write per cycle while WrReady=1 (back-to-back accept and drain in the same cycle).
- Requester rule: ReqSel/ReqData stay stable and ReqValid stays high until accepted. The arbiter does not re-check this rule.
- Flush:
  - Synchronous and highest priority.
  - Next cycle: WrEnable=0, RrPtr=0. No acceptance in the flush cycle.
  - WrSel/WrData hold their values.
- Asynchronous reset mid-write: all state clears immediately; the pending write is lost.
- Simultaneous requests to the same register from different requesters: serviced in grant order, so the last accepted value wins.

Optional Feature:
- Macro: WBARB_FIXED_PRIO_EN.
- When defined:
  - Fixed priority replaces round-robin: lowest index wins.
  - RrPtr is removed and stays at 0.
  - LastGrant still updates.
- When undefined: round-robin as above.

Test Plan:
1. Reset, then ReqValid=4'b0001, ReqSel0=5, ReqData0=32'hDEADBEEF, WrReady=1 -> ReqReady=0001 in cycle 0; next cycle WrEnable=1, WrSel=5, WrData=DEADBEEF; following cycle WrEnable=0.
2. ReqValid=4'b1111 held, all Sel nonzero, WrReady=1 -> grants 0,1,2,3,0 on consecutive cycles, LastGrant follows. With WBARB_FIXED_PRIO_EN -> grant 0 every cycle.
3. Write pending with WrReady=0 for 3 cycles -> WrEnable/WrSel/WrData stable, ReqReady=0, RrPtr unchanged; WrReady=1 -> drain and accept next request in the same cycle.
4. ReqSel1=0, ReqValid=4'b0010 -> ReqReady=0010, next cycle WrEnable=0, LastGrant=1, RrPtr=2.
5. Flush asserted while WrEnable=1 and ReqValid=4'b0100 -> ReqReady=0, next cycle WrEnable=0, RrPtr=0; following cycle grant to requester 2.
6. Reset_n pulsed low mid-stream (asynchronous, between edges) -> WrEnable, WrSel, WrData, LastGrant drop to 0 immediately, ReqReady=0 while low.
